usb_data_fifo: RTL and testbench

Parametrised circular-buffer FIFO that replaces the fixed 64-byte shift-register data buffer between the USB protocol controllers and the host-side interface. A single storage array is shared by the TX path (host writes, TX packet encoder reads) and the RX path (RX packet decoder writes, host reads). Read and write pointers replace byte shifting. The block adds full/empty/almost-full status, sticky overflow/underflow error flags, and a distinction between flush and clear.

---
 rtl/usb_data_fifo.sv | 121 ++++++++++++
 tb/tb_usb_data_fifo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_data_fifo.sv
// usb_data_fifo: shared circular-buffer FIFO between the USB protocol
// controllers and the host-side interface. TX and RX paths share one
// storage array; pointers move instead of data, and a registered count
// tracks occupancy. Flush empties the buffer; clear also wipes the error
// flags and the output registers.
module usb_data_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AFULL_LVL = DEPTH - 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_tx,
    input  logic [DATA_W-1:0]        tx_data,
    input  logic                     store_rx,
    input  logic [DATA_W-1:0]        rx_packet_data,
    input  logic                     get_tx,
    input  logic                     get_rx,
    input  logic                     flush,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [DATA_W-1:0]        tx_packet_data,
    output logic [DATA_W-1:0]        rx_data,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;

    logic              flush_any;
    logic              push_req;
    logic              pop_req;
    logic              push_ok;
    logic              pop_ok;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    // Request arbitration and acceptance; flush/clear suppress all traffic.
    // A push into a full buffer is allowed only when a pop frees a slot
    // in the same cycle; an empty buffer never forwards push data to a pop.
    always_comb begin
        flush_any = flush | clear;
        push_req  = store_tx | store_rx;
        pop_req   = get_tx | get_rx;
        pop_ok    = pop_req && (count != '0) && !flush_any;
        push_ok   = push_req && ((count != OCC_W'(DEPTH)) || pop_ok) && !flush_any;
        wr_data   = store_tx ? tx_data : rx_packet_data;
        rd_data   = mem[rd_ptr];
    end

    // Storage array write port; contents are don't-care after flush/reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count, output registers and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tx_packet_data <= '0;
            rx_data        <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tx_packet_data <= '0;
            rx_data        <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (get_tx) begin
                    tx_packet_data <= rd_data;
                end else begin
                    rx_data <= rd_data;
                end
            end
            if (push_ok && !pop_ok) begin
                count <= count + OCC_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - OCC_W'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop_req && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    // Status flags decoded straight from the registered count.
    assign occupancy   = count;
    assign empty       = (count == '0);
    assign full        = (count == OCC_W'(DEPTH));
    assign almost_full = (count >= OCC_W'(AFULL_LVL));

endmodule

// File: tb/tb_usb_data_fifo.sv
// Directed bench for usb_data_fifo: stimulus queues expected values, a
// negedge monitor drains and compares them against the DUT outputs.
module tb_usb_data_fifo;

    localparam int DEPTH = 64;

    localparam int K_OCC  = 0;
    localparam int K_EMP  = 1;
    localparam int K_FULL = 2;
    localparam int K_AF   = 3;
    localparam int K_TX   = 4;
    localparam int K_RX   = 5;
    localparam int K_OVF  = 6;
    localparam int K_UNF  = 7;

    logic       clk;
    logic       rst;
    logic       store_tx;
    logic [7:0] tx_data;
    logic       store_rx;
    logic [7:0] rx_packet_data;
    logic       get_tx;
    logic       get_rx;
    logic       flush;
    logic       clear;
    logic [6:0] occupancy;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [7:0] tx_packet_data;
    logic [7:0] rx_data;
    logic       overflow;
    logic       underflow;

    typedef struct {
        int          kind;
        int unsigned val;
        string       name;
    } chk_t;

    chk_t       cq[$];
    logic [7:0] mq[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       done  = 1'b0;

    usb_data_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AFULL_LVL(DEPTH - 8)) dut (
        .clk(clk), .rst(rst),
        .store_tx(store_tx), .tx_data(tx_data),
        .store_rx(store_rx), .rx_packet_data(rx_packet_data),
        .get_tx(get_tx), .get_rx(get_rx),
        .flush(flush), .clear(clear),
        .occupancy(occupancy), .empty(empty), .full(full),
        .almost_full(almost_full),
        .tx_packet_data(tx_packet_data), .rx_data(rx_data),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned actual(input int k);
        case (k)
            K_OCC:   return 32'(occupancy);
            K_EMP:   return 32'(empty);
            K_FULL:  return 32'(full);
            K_AF:    return 32'(almost_full);
            K_TX:    return 32'(tx_packet_data);
            K_RX:    return 32'(rx_data);
            K_OVF:   return 32'(overflow);
            K_UNF:   return 32'(underflow);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic exp(input int k, input int unsigned v, input string nm);
        chk_t c;
        c.kind = k;
        c.val  = v;
        c.name = nm;
        cq.push_back(c);
    endtask

    // Immediate comparison, used where no clock edge may intervene.
    task automatic chk_now(input int k, input int unsigned v, input string nm);
        int unsigned a;
        a = actual(k);
        n_vec++;
        if (a != v) begin
            n_err++;
            $display("FAIL %s (immediate): got 0x%0h, expected 0x%0h at %0t",
                     nm, a, v, $time);
        end
    endtask

    // One clock of stimulus; inputs return to idle just after the edge.
    task automatic cyc(input logic stx, input logic [7:0] td,
                       input logic srx, input logic [7:0] rd,
                       input logic gtx, input logic grx,
                       input logic fl, input logic cl);
        store_tx = stx; tx_data = td;
        store_rx = srx; rx_packet_data = rd;
        get_tx = gtx; get_rx = grx;
        flush = fl; clear = cl;
        @(posedge clk);
        #1;
        store_tx = 1'b0; tx_data = 8'h00;
        store_rx = 1'b0; rx_packet_data = 8'h00;
        get_tx = 1'b0; get_rx = 1'b0;
        flush = 1'b0; clear = 1'b0;
    endtask

    // Monitor: compares every queued expectation at the falling edge.
    initial begin
        chk_t        c;
        int unsigned a;
        forever begin
            @(negedge clk);
            while (cq.size() > 0) begin
                c = cq.pop_front();
                a = actual(c.kind);
                n_vec++;
                if (a != c.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                             c.name, a, c.val, $time);
                end
            end
        end
    end

    // Watchdog: the run must complete within a bounded time.
    initial begin
        #1_000_000;
        if (!done) begin
            n_err++;
            $display("FAIL watchdog: stimulus did not complete at %0t", $time);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // Directed stimulus.
    initial begin
        logic [7:0] basic [3];
        logic [7:0] p;
        logic [7:0] last_rx;
        logic [7:0] v;

        basic[0] = 8'h11; basic[1] = 8'h22; basic[2] = 8'h33;
        rst = 1'b1;
        store_tx = 1'b0; tx_data = 8'h00;
        store_rx = 1'b0; rx_packet_data = 8'h00;
        get_tx = 1'b0; get_rx = 1'b0;
        flush = 1'b0; clear = 1'b0;

        exp(K_OCC, 0, "rst_occ");  exp(K_EMP, 1, "rst_empty");
        exp(K_FULL, 0, "rst_full"); exp(K_AF, 0, "rst_afull");
        exp(K_TX, 0, "rst_tx");    exp(K_RX, 0, "rst_rx");
        exp(K_OVF, 0, "rst_ovf");  exp(K_UNF, 0, "rst_unf");
        @(posedge clk);
        #1;
        chk_now(K_OCC, 0, "rst_now_occ");
        chk_now(K_EMP, 1, "rst_now_empty");
        chk_now(K_OVF, 0, "rst_now_ovf");
        chk_now(K_UNF, 0, "rst_now_unf");
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic flow through the TX path.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, basic[i], 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            exp(K_OCC, 32'(i + 1), "basic_push_occ");
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            exp(K_TX, 32'(basic[i]), "basic_pop_tx");
            exp(K_OCC, 32'(2 - i), "basic_pop_occ");
            exp(K_RX, 0, "basic_rx_zero");
        end

        // Fill to DEPTH, then overflow and full-throughput corner.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            mq.push_back(8'(i));
            if (i == 54 || i == 55) exp(K_AF, (i == 55) ? 1 : 0, "fill_afull");
            if (i == 62 || i == 63) exp(K_FULL, (i == 63) ? 1 : 0, "fill_full");
        end
        exp(K_OVF, 0, "fill_no_ovf");
        cyc(1'b0, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        exp(K_OCC, 64, "ovf_occ");
        exp(K_OVF, 1, "ovf_flag");
        cyc(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp(K_RX, 32'(mq.pop_front()), "full_pushpop_rx");
        mq.push_back(8'hFF);
        exp(K_OCC, 64, "full_pushpop_occ");
        exp(K_FULL, 1, "full_pushpop_full");

        // Drain down to 10 entries.
        for (int i = 0; i < 54; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            exp(K_TX, 32'(mq.pop_front()), "drain_tx");
        end
        exp(K_OCC, 10, "drain_occ");

        // Flush with a concurrent push: push ignored, errors/outputs kept.
        cyc(1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        mq.delete();
        exp(K_OCC, 0, "flush_occ");   exp(K_EMP, 1, "flush_empty");
        exp(K_OVF, 1, "flush_ovf");   exp(K_TX, 32'h36, "flush_tx_held");
        exp(K_RX, 0, "flush_rx_held");

        // Empty corner cases.
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        exp(K_UNF, 1, "empty_pop_unf");
        exp(K_TX, 32'h36, "empty_pop_tx_held");
        exp(K_OCC, 0, "empty_pop_occ");
        cyc(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        exp(K_OCC, 1, "empty_pushpop_occ");
        exp(K_TX, 32'h36, "empty_pushpop_tx");
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        exp(K_TX, 32'hA5, "empty_next_pop");
        exp(K_OCC, 0, "empty_next_occ");

        // Sustained push+pop at occupancy 5 across pointer wrap.
        p = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, p, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            mq.push_back(p);
            p = p + 8'h01;
        end
        exp(K_OCC, 5, "wrap_prefill_occ");
        last_rx = 8'h00;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, p, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            mq.push_back(p);
            p = p + 8'h01;
            last_rx = mq.pop_front();
            exp(K_RX, 32'(last_rx), "wrap_rx");
            exp(K_OCC, 5, "wrap_occ");
        end

        // Write and read priority.
        cyc(1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        mq.push_back(8'h01);
        exp(K_OCC, 6, "prio_push_occ");
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        exp(K_TX, 32'(mq.pop_front()), "prio_pop_tx");
        exp(K_RX, 32'(last_rx), "prio_pop_rx_held");
        exp(K_OCC, 5, "prio_pop_occ");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            exp(K_RX, 32'(mq.pop_front()), "prio_drain_rx");
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        v = mq.pop_front();
        exp(K_RX, 32'h01, "prio_only_tx_stored");
        exp(K_OCC, 0, "prio_last_occ");
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp(K_RX, 32'h01, "prio_no_rx_entry");
        exp(K_UNF, 1, "prio_unf");

        // Clear at occupancy 10 with errors set.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'h80 + 8'(i)), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        exp(K_OCC, 10, "clr_pre_occ");
        exp(K_OVF, 1, "clr_pre_ovf");
        cyc(1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        exp(K_OCC, 0, "clr_occ");  exp(K_EMP, 1, "clr_empty");
        exp(K_OVF, 0, "clr_ovf");  exp(K_UNF, 0, "clr_unf");
        exp(K_TX, 0, "clr_tx");    exp(K_RX, 0, "clr_rx");

        // Asynchronous reset at occupancy 30.
        for (int i = 0; i < 33; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp(K_OCC, 30, "prerst_occ");
        exp(K_TX, 32'h02, "prerst_tx");
        exp(K_RX, 32'h03, "prerst_rx");
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk_now(K_OCC, 0, "arst_now_occ");
        chk_now(K_EMP, 1, "arst_now_empty");
        chk_now(K_TX, 0, "arst_now_tx");
        chk_now(K_RX, 0, "arst_now_rx");
        chk_now(K_OVF, 0, "arst_now_ovf");
        chk_now(K_UNF, 0, "arst_now_unf");
        exp(K_OCC, 0, "arst_occ");  exp(K_EMP, 1, "arst_empty");
        exp(K_TX, 0, "arst_tx");    exp(K_RX, 0, "arst_rx");
        exp(K_AF, 0, "arst_afull"); exp(K_FULL, 0, "arst_full");
        @(posedge clk);
        #1 rst = 1'b0;

        // Operation resumes normally after reset.
        cyc(1'b1, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp(K_OCC, 1, "post_rst_occ");
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        exp(K_RX, 32'h42, "post_rst_rx");
        exp(K_OCC, 0, "post_rst_empty_occ");

        repeat (2) @(posedge clk);
        if (cq.size() != 0) begin
            n_err++;
            $display("FAIL %0d expectations never compared", cq.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule
